// File: rtl/ram8_block_mover_pkg.sv
// ----------------------------------------------------------------------------
// ram8_block_mover_pkg
// Shared definitions for the RAM8 block mover.
//   - Default word and address widths for the 8 x 16 RAM port.
//   - Transfer mode constants (copy / fill).
//   - FSM state encodings (IDLE, READ, WRITE, DONE).
// ----------------------------------------------------------------------------
package ram8_block_mover_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/ram8_block_mover_wrap_addr.sv
// ----------------------------------------------------------------------------
// wrap_addr
// Computes (base + offset) modulo 2^ADDR_W. The sum is simply truncated to
// ADDR_W bits, so address 7 + 1 wraps to 0 for an 8-deep RAM.
// Ports:
//   base   in  ADDR_W  starting address
//   offset in  ADDR_W  word offset (low bits of the transfer count)
//   sum    out ADDR_W  wrapped address
// ----------------------------------------------------------------------------
module wrap_addr
   import ram8_block_mover_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] offset,
   output logic [ADDR_W-1:0] sum
);

   assign sum = base + offset;

endmodule

// File: rtl/ram8_block_mover.sv
// ----------------------------------------------------------------------------
// ram8_block_mover
// Bus master for one ram8 port. On start it copies len words from src to dst
// (ascending, one word at a time: READ then WRITE) or fills len words at dst
// with a constant (one WRITE per word). Owns the RAM port while busy.
// Ports:
//   clk, reset          clock / asynchronous active-high reset
//   start, mode         request pulse (IDLE only), 0 = copy, 1 = fill
//   src, dst, len       source, destination, word count (0..8)
//   fill_value          word written in fill mode
//   busy, done          transfer in progress / one-cycle completion pulse
//   mem_address,
//   mem_load, mem_in    drive the RAM
//   mem_out             combinational RAM read data
// ----------------------------------------------------------------------------
module ram8_block_mover
   import ram8_block_mover_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_load,
   output logic [DATA_W-1:0] mem_in,
   input  logic [DATA_W-1:0] mem_out
);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] buf_q,   buf_d;
   logic              mode_q,  mode_d;
   logic [ADDR_W-1:0] src_q,   src_d;
   logic [ADDR_W-1:0] dst_q,   dst_d;
   logic [ADDR_W:0]   len_q,   len_d;
   logic [DATA_W-1:0] fill_q,  fill_d;

   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [ADDR_W:0]   count_inc;

   wrap_addr #(.ADDR_W(ADDR_W)) u_src_addr (
      .base   (src_q),
      .offset (count_q[ADDR_W-1:0]),
      .sum    (src_addr)
   );

   wrap_addr #(.ADDR_W(ADDR_W)) u_dst_addr (
      .base   (dst_q),
      .offset (count_q[ADDR_W-1:0]),
      .sum    (dst_addr)
   );

   // Full-width increment so len = 8 is reachable without the counter wrapping.
   assign count_inc = count_q + 1'b1;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      buf_d   = buf_q;
      mode_d  = mode_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      fill_d  = fill_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d  = mode;
               src_d   = src;
               dst_d   = dst;
               len_d   = len;
               fill_d  = fill_value;
               count_d = '0;
               if (len == '0)
                  state_d = ST_DONE;
               else if (mode == MODE_FILL)
                  state_d = ST_WRITE;
               else
                  state_d = ST_READ;
            end
         end
         ST_READ: begin
            // RAM output is combinational on mem_address, so the word for
            // src+count is valid by the end of this cycle.
            buf_d   = mem_out;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            count_d = count_inc;
            if (count_inc == len_q)
               state_d = ST_DONE;
            else if (mode_q == MODE_FILL)
               state_d = ST_WRITE;
            else
               state_d = ST_READ;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         buf_q   <= '0;
         mode_q  <= MODE_COPY;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         buf_q   <= buf_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         fill_q  <= fill_d;
      end
   end

   // Memory-side outputs depend only on registered state, never on start.
   always_comb begin
      busy        = (state_q != ST_IDLE);
      done        = (state_q == ST_DONE);
      mem_address = '0;
      mem_load    = 1'b0;
      mem_in      = '0;
      case (state_q)
         ST_READ: begin
            mem_address = src_addr;
         end
         ST_WRITE: begin
            mem_address = dst_addr;
            mem_load    = 1'b1;
            mem_in      = (mode_q == MODE_FILL) ? fill_q : buf_q;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_ram8_block_mover.sv
// ----------------------------------------------------------------------------
// tb_ram8_block_mover
// Bench for ram8_block_mover with a behavioural 8 x 16 RAM attached.
// ----------------------------------------------------------------------------
module tb_ram8_block_mover;
   import ram8_block_mover_pkg::*;

   localparam int DW = 16;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          mode;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [AW:0]   len;
   logic [DW-1:0] fill_value;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_address;
   logic          mem_load;
   logic [DW-1:0] mem_in;
   logic [DW-1:0] mem_out;

   always #5 clk = ~clk;

   ram8_block_mover #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mode        (mode),
      .src         (src),
      .dst         (dst),
      .len         (len),
      .fill_value  (fill_value),
      .busy        (busy),
      .done        (done),
      .mem_address (mem_address),
      .mem_load    (mem_load),
      .mem_in      (mem_in),
      .mem_out     (mem_out)
   );

   // Behavioural RAM: combinational read, write on rising edge.
   logic [DW-1:0] ram [8];
   logic          tb_we;
   logic [AW-1:0] tb_addr;
   logic [DW-1:0] tb_data;

   always @(posedge clk) begin
      if (mem_load)
         ram[mem_address] <= mem_in;
      else if (tb_we)
         ram[tb_addr] <= tb_data;
   end

   assign mem_out = ram[mem_address];

   // Reference memory and expected per-cycle bus activity.
   logic [DW-1:0] model [8];

   typedef struct {
      logic [AW-1:0] addr;
      logic          load;
      logic [DW-1:0] data;
      logic          chk_data;
   } ev_t;

   ev_t exp_q[$];

   typedef struct {
      int            preload;   // 0 keep, 1 = 0x1000+i, 2 = i
      logic          mode;
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [AW:0]   len;
      logic [DW-1:0] fill;
      int            done_cyc;  // cycle after accept in which done is high
   } vec_t;

   vec_t vecs [5];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int kind);
      for (int i = 0; i < 8; i++) begin
         tb_we   = 1'b1;
         tb_addr = AW'(i);
         tb_data = (kind == 1) ? DW'(16'h1000 + i) : DW'(i);
         model[i] = tb_data;
         step();
      end
      tb_we = 1'b0;
   endtask

   task automatic push_expected(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                                input logic [AW:0] l, input logic [DW-1:0] f);
      ev_t           e;
      logic [AW-1:0] sa;
      logic [AW-1:0] da;
      for (int k = 0; k < int'(l); k++) begin
         sa = s + AW'(k);
         da = d + AW'(k);
         if (m == MODE_COPY) begin
            e.addr = sa; e.load = 1'b0; e.data = '0; e.chk_data = 1'b0;
            exp_q.push_back(e);
            model[da] = model[sa];
            e.addr = da; e.load = 1'b1; e.data = model[da]; e.chk_data = 1'b1;
            exp_q.push_back(e);
         end else begin
            model[da] = f;
            e.addr = da; e.load = 1'b1; e.data = f; e.chk_data = 1'b1;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic check_ram(input string tag);
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s_ram%0d", tag, i), 32'(ram[i]), 32'(model[i]));
   endtask

   // Called in an IDLE cycle (#1 after an edge).
   task automatic run_xfer(input string tag, input logic m, input logic [AW-1:0] s,
                           input logic [AW-1:0] d, input logic [AW:0] l,
                           input logic [DW-1:0] f, input int done_cyc);
      ev_t e;
      int  cyc;
      bit  fin;
      push_expected(m, s, d, l, f);
      start = 1'b1; mode = m; src = s; dst = d; len = l; fill_value = f;
      step();
      // Scramble request inputs while busy; they must be ignored.
      start = 1'b0; mode = ~m; src = s + 3'd3; dst = d + 3'd5; len = 4'd1; fill_value = ~f;
      cyc = 1;
      fin = 1'b0;
      while (!fin && cyc <= 40) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_c%0d_addr", tag, cyc), 32'(mem_address), 32'(e.addr));
            chk($sformatf("%s_c%0d_load", tag, cyc), 32'(mem_load), 32'(e.load));
            if (e.chk_data)
               chk($sformatf("%s_c%0d_data", tag, cyc), 32'(mem_in), 32'(e.data));
            chk($sformatf("%s_c%0d_busy", tag, cyc), 32'(busy), 32'd1);
            chk($sformatf("%s_c%0d_done", tag, cyc), 32'(done), 32'd0);
            step();
            cyc++;
         end else begin
            chk($sformatf("%s_done_cycle", tag), 32'(cyc), 32'(done_cyc));
            chk($sformatf("%s_done", tag), 32'(done), 32'd1);
            chk($sformatf("%s_done_busy", tag), 32'(busy), 32'd1);
            chk($sformatf("%s_done_load", tag), 32'(mem_load), 32'd0);
            chk($sformatf("%s_done_addr", tag), 32'(mem_address), 32'd0);
            chk($sformatf("%s_done_in", tag), 32'(mem_in), 32'd0);
            fin = 1'b1;
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_done required=done_by_cycle_%0d", tag, done_cyc);
      end
      step();
      chk($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
      chk($sformatf("%s_idle_done", tag), 32'(done), 32'd0);
      check_ram(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int loads;
      int dones;

      vecs[0] = '{preload: 1, mode: MODE_COPY, src: 3'd0, dst: 3'd4, len: 4'd3, fill: 16'h0,    done_cyc: 7};
      vecs[1] = '{preload: 1, mode: MODE_COPY, src: 3'd6, dst: 3'd1, len: 4'd4, fill: 16'h0,    done_cyc: 9};
      vecs[2] = '{preload: 0, mode: MODE_FILL, src: 3'd0, dst: 3'd5, len: 4'd8, fill: 16'hBEEF, done_cyc: 9};
      vecs[3] = '{preload: 2, mode: MODE_COPY, src: 3'd0, dst: 3'd1, len: 4'd3, fill: 16'h0,    done_cyc: 7};
      vecs[4] = '{preload: 0, mode: MODE_COPY, src: 3'd2, dst: 3'd6, len: 4'd0, fill: 16'h0,    done_cyc: 1};

      reset = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
      fill_value = '0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
      step();
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_load", 32'(mem_load), 32'd0);
      chk("rst_addr", 32'(mem_address), 32'd0);
      chk("rst_in",   32'(mem_in), 32'd0);
      reset = 1'b0;
      step();

      for (int v = 0; v < 5; v++) begin
         if (vecs[v].preload != 0)
            preload(vecs[v].preload);
         run_xfer($sformatf("vec%0d", v), vecs[v].mode, vecs[v].src, vecs[v].dst,
                  vecs[v].len, vecs[v].fill, vecs[v].done_cyc);
         if (v == 0) begin
            chk("copy_ram4", 32'(ram[4]), 32'h1000);
            chk("copy_ram5", 32'(ram[5]), 32'h1001);
            chk("copy_ram6", 32'(ram[6]), 32'h1002);
            chk("copy_ram7", 32'(ram[7]), 32'h1007);
            chk("copy_ram3", 32'(ram[3]), 32'h1003);
         end
         if (v == 3) begin
            chk("ovl_ram1", 32'(ram[1]), 32'h0);
            chk("ovl_ram2", 32'(ram[2]), 32'h0);
            chk("ovl_ram3", 32'(ram[3]), 32'h0);
            chk("ovl_ram4", 32'(ram[4]), 32'h4);
         end
      end

      // start held high through a len=2 copy: exactly one transfer.
      preload(1);
      push_expected(MODE_COPY, 3'd0, 3'd5, 4'd2, 16'h0);
      exp_q.delete();
      start = 1'b1; mode = MODE_COPY; src = 3'd0; dst = 3'd5; len = 4'd2; fill_value = 16'h0;
      loads = 0;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (mem_load) loads++;
         if (done) begin
            dones++;
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("hold_loads", 32'(loads), 32'd2);
      chk("hold_dones", 32'(dones), 32'd1);
      chk("hold_busy",  32'(busy), 32'd0);
      check_ram("hold");

      // Reset during the second WRITE of a len=4 fill.
      preload(1);
      start = 1'b1; mode = MODE_FILL; dst = 3'd2; len = 4'd4; fill_value = 16'hAAAA;
      step();
      start = 1'b0;
      chk("mid_w1_addr", 32'(mem_address), 32'd2);
      step();
      chk("mid_w2_load", 32'(mem_load), 32'd1);
      chk("mid_w2_addr", 32'(mem_address), 32'd3);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_load", 32'(mem_load), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_addr", 32'(mem_address), 32'd0);
      chk("mid_rst_in",   32'(mem_in), 32'd0);
      step();
      step();
      reset = 1'b0;
      step();
      chk("mid_ram2", 32'(ram[2]), 32'hAAAA);
      chk("mid_ram3", 32'(ram[3]), 32'h1003);
      chk("mid_ram4", 32'(ram[4]), 32'h1004);
      chk("mid_ram5", 32'(ram[5]), 32'h1005);
      model[2] = 16'hAAAA;
      run_xfer("after_rst", MODE_FILL, 3'd3, 3'd3, 4'd1, 16'h5555, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
